// File: rtl/conv_stream_tx.sv
// conv_stream_tx
//   Stream partner for the convolution core. Holds the f and x vectors in a
//   local buffer loaded through a simple write port. On start it streams the
//   buffer (f first, then x) as an AXI-stream master. Concurrently it acts as
//   the AXI-stream slave for the core's y output, captures every y word into
//   a result buffer, and pulses done once all results have arrived.
//
// Ports
//   clk      in   clock
//   reset    in   synchronous, active-low reset
//   ld_en    in   buffer write strobe (honoured only in IDLE, not with start)
//   ld_addr  in   buffer write address (f at 0..F_SIZE-1, x above)
//   ld_data  in   buffer write data
//   start    in   one-cycle run request (ignored outside IDLE)
//   m_data   out  stream data to the core
//   m_valid  out  stream valid to the core
//   m_ready  in   core ready
//   s_data   in   y data from the core
//   s_valid  in   core y valid
//   s_ready  out  ready for y
//   rd_addr  in   result buffer read address
//   rd_data  out  result word (combinational read)
//   busy     out  high from accepted start until done
//   done     out  one-cycle pulse after the final y capture
//
// Build option
//   CONV_TX_THROTTLE_EN : free-running 2-bit counter drops m_valid when it is
//   3 and s_ready when it is 1, to stress the core's flow control.

module conv_stream_tx #(
    parameter int T      = 8,
    parameter int Y_W    = 20,
    parameter int F_SIZE = 32,
    parameter int X_SIZE = 128,
    parameter int Y_SIZE = X_SIZE - F_SIZE + 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ld_en,
    input  logic [$clog2(F_SIZE+X_SIZE)-1:0]  ld_addr,
    input  logic [T-1:0]                      ld_data,
    input  logic                              start,
    output logic [T-1:0]                      m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    input  logic [Y_W-1:0]                    s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [$clog2(Y_SIZE)-1:0]         rd_addr,
    output logic [Y_W-1:0]                    rd_data,
    output logic                              busy,
    output logic                              done
);

    localparam int N   = F_SIZE + X_SIZE;
    localparam int LAW = $clog2(N);
    localparam int TXW = $clog2(N + 1);
    localparam int RXW = $clog2(Y_SIZE + 1);
    localparam int RAW = $clog2(Y_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        SEND,
        DRAIN,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [T-1:0]   buf_q [N];
    logic [Y_W-1:0] res_q [Y_SIZE];

    logic [T-1:0]   m_data_q;
    logic           m_valid_q;
    logic           s_ready_q;
    logic [TXW-1:0] tx_cnt_q;
    logic [TXW-1:0] tx_nxt;
    logic [RXW-1:0] rx_cnt_q;

    logic gap_tx, gap_rx;
    logic start_ok, tx_fire, tx_last, rx_fire, rx_last, rx_done_now;

`ifdef CONV_TX_THROTTLE_EN
    logic [1:0] thr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            thr_q <= '0;
        end else begin
            thr_q <= thr_q + 2'd1;
        end
    end

    assign gap_tx = (thr_q == 2'd3);
    assign gap_rx = (thr_q == 2'd1);
`else
    assign gap_tx = 1'b0;
    assign gap_rx = 1'b0;
`endif

    // Throttle gaps only mask the outputs; the held word and its valid
    // register stay put, so a stalled beat survives the gap unchanged.
    assign m_valid = m_valid_q & ~gap_tx;
    assign s_ready = s_ready_q & ~gap_rx;
    assign m_data  = m_data_q;

    assign start_ok = start && (state_q == IDLE);
    assign tx_fire  = m_valid && m_ready;
    assign tx_last  = tx_fire && (tx_cnt_q == TXW'(N - 1));
    assign tx_nxt   = tx_cnt_q + TXW'(1);
    assign rx_fire  = s_valid && s_ready;
    assign rx_last  = rx_fire && (rx_cnt_q == RXW'(Y_SIZE - 1));
    // Results are complete either already or with this cycle's capture, so a
    // last capture coinciding with the last tx beat goes straight to DONE.
    assign rx_done_now = (rx_cnt_q == RXW'(Y_SIZE)) || rx_last;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = PREFETCH;
            PREFETCH: state_d = SEND;
            SEND:     if (tx_last) state_d = rx_done_now ? DONE : DRAIN;
            DRAIN:    if (rx_done_now) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            PREFETCH, SEND, DRAIN: busy = 1'b1;
            DONE:                  done = 1'b1;
            default: ;
        endcase
    end

    // Transmit / receive datapath
    always_ff @(posedge clk) begin
        if (!reset) begin
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
        end else begin
            if (start_ok) begin
                tx_cnt_q  <= '0;
                rx_cnt_q  <= '0;
                s_ready_q <= 1'b1;
            end
            if (state_q == PREFETCH) begin
                m_data_q  <= buf_q[0];
                m_valid_q <= 1'b1;
            end
            // The read port is addressed with the index of the following
            // word, so the next beat is registered on the transfer edge and
            // the stream runs at one beat per cycle.
            if (tx_fire) begin
                tx_cnt_q <= tx_nxt;
                if (tx_last) begin
                    m_valid_q <= 1'b0;
                end else begin
                    m_data_q <= buf_q[tx_nxt[LAW-1:0]];
                end
            end
            if (rx_fire) begin
                rx_cnt_q <= rx_cnt_q + RXW'(1);
                if (rx_last) begin
                    s_ready_q <= 1'b0;
                end
            end
        end
    end

    // Input buffer: written only while idle, never cleared
    always_ff @(posedge clk) begin
        if (reset && (state_q == IDLE) && ld_en && !start && (int'(ld_addr) < N)) begin
            buf_q[ld_addr] <= ld_data;
        end
    end

    // Result buffer: never cleared
    always_ff @(posedge clk) begin
        if (reset && rx_fire) begin
            res_q[rx_cnt_q[RAW-1:0]] <= s_data;
        end
    end

    assign rd_data = (int'(rd_addr) < Y_SIZE) ? res_q[rd_addr] : '0;

endmodule
